gpu_rect_fill: RTL and testbench

Parametrised frame-buffer fill engine sitting between the CPU-side GPU command registers and the GPU–SRAM port. It accepts one rectangle command at a time and writes every pixel of the rectangle into the linear frame buffer, one pixel per clock. Fill modes are solid, checkerboard and blink. SRAM writes happen only while the display is blanked (`I_VIDEO_ON` low). It generalises the fixed full-screen flashing fill to arbitrary resolution, arbitrary rectangles, and a command handshake with completion status.

---
 rtl/gpu_rect_fill_pkg.sv | 24 ++
 rtl/gpu_pixel_color.sv | 34 +++
 rtl/gpu_rect_fill.sv | 209 ++++++++++++++++++++
 tb/tb_gpu_rect_fill.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_rect_fill_pkg.sv
// -----------------------------------------------------------------------------
// gpu_rect_fill_pkg
// Shared GPU defines: status register width, rectangle fill mode encodings and
// the fill engine's state encodings.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package gpu_rect_fill_pkg;

    // Width of the GPU status register seen by the CPU-side register block.
    localparam int GSR_WIDTH = 8;

    // Fill modes carried on I_CMD_MODE; the fourth code is reserved and
    // behaves like solid.
    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_CHECKER = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;

    // Fill engine states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/gpu_pixel_color.sv
// -----------------------------------------------------------------------------
// gpu_pixel_color
// Combinational colour select for one pixel of a rectangle fill.
//   mode        : fill mode (solid / checker / blink, reserved = solid)
//   chk_x/chk_y : checker-size bit of the pixel's x and y coordinates
//   blink_phase : current blink phase from the free-running counter
//   color_a/b   : primary and secondary colours
//   color       : selected pixel colour
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module gpu_pixel_color
    import gpu_rect_fill_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [1:0]        mode,
    input  logic              chk_x,
    input  logic              chk_y,
    input  logic              blink_phase,
    input  logic [DATA_W-1:0] color_a,
    input  logic [DATA_W-1:0] color_b,
    output logic [DATA_W-1:0] color
);

    always_comb begin
        case (mode)
            MODE_CHECKER: color = (chk_x ^ chk_y) ? color_b : color_a;
            MODE_BLINK:   color = blink_phase     ? color_b : color_a;
            default:      color = color_a;
        endcase
    end

endmodule

// File: rtl/gpu_rect_fill.sv
// -----------------------------------------------------------------------------
// gpu_rect_fill
// Frame-buffer rectangle fill engine. Accepts one command at a time and writes
// every pixel of the (clamped) rectangle into the linear frame buffer, one
// pixel per blanked clock.
//   I_CLK, I_RST_N            : clock, asynchronous active-low reset
//   I_VIDEO_ON                : display scanning; SRAM writes held off
//   I_CMD_VALID / O_CMD_READY : command handshake (ready while idle)
//   I_CMD_MODE                : 0 solid, 1 checker, 2 blink, 3 solid
//   I_X0, I_Y0, I_X1, I_Y1    : inclusive rectangle corners
//   I_COLOR_A, I_COLOR_B      : primary / secondary colours
//   O_GPU_ADDR/DATA/WRITE     : SRAM write port (address/data hold when idle)
//   O_GPU_READ                : tied low
//   O_GPUStallSignal          : high while a rectangle is being drawn
//   O_DONE                    : one-cycle completion pulse
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module gpu_rect_fill
    import gpu_rect_fill_pkg::*;
#(
    parameter int H_RES     = 640,
    parameter int V_RES     = 400,
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int COORD_W   = 10,
    parameter int CHK_BIT   = 3,
    parameter int BLINK_BIT = 23
) (
    input  logic               I_CLK,
    input  logic               I_RST_N,
    input  logic               I_VIDEO_ON,
    input  logic               I_CMD_VALID,
    output logic               O_CMD_READY,
    input  logic [1:0]         I_CMD_MODE,
    input  logic [COORD_W-1:0] I_X0,
    input  logic [COORD_W-1:0] I_Y0,
    input  logic [COORD_W-1:0] I_X1,
    input  logic [COORD_W-1:0] I_Y1,
    input  logic [DATA_W-1:0]  I_COLOR_A,
    input  logic [DATA_W-1:0]  I_COLOR_B,
    output logic [ADDR_W-1:0]  O_GPU_ADDR,
    output logic [DATA_W-1:0]  O_GPU_DATA,
    output logic               O_GPU_WRITE,
    output logic               O_GPU_READ,
    output logic               O_GPUStallSignal,
    output logic               O_DONE
);

    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0]  STRIDE = ADDR_W'(H_RES);

    logic [1:0]         state;
    logic [1:0]         mode_q;
    logic [DATA_W-1:0]  color_a_q, color_b_q;
    logic [COORD_W-1:0] x0_q, x1_q, y1_q;
    logic [COORD_W-1:0] x_q, y_q;            // next pixel to write
    logic [ADDR_W-1:0]  base_q;              // y_q * H_RES
    logic               pend_q;              // pixels still to write
    logic [BLINK_BIT:0] cnt_q;

    // Clamped corners and emptiness of the command on the inputs.
    logic [COORD_W-1:0] x1_clamp, y1_clamp;
    logic               cmd_empty;

    assign x1_clamp  = (I_X1 > X_MAX) ? X_MAX : I_X1;
    assign y1_clamp  = (I_Y1 > Y_MAX) ? Y_MAX : I_Y1;
    assign cmd_empty = (I_X0 > x1_clamp) || (I_Y0 > y1_clamp) ||
                       (int'(I_X0) >= H_RES) || (int'(I_Y0) >= V_RES);

    // The pixel about to be issued. In IDLE it comes straight from the command
    // inputs so the first write lands in the cycle right after acceptance.
    logic [COORD_W-1:0] cur_x, cur_y, sel_x0, sel_x1, sel_y1;
    logic [ADDR_W-1:0]  cur_base;
    logic [1:0]         sel_mode;
    logic [DATA_W-1:0]  sel_a, sel_b;

    always_comb begin
        // NOTE: every branch assigns every output, so no latch is inferred.
        if (state == ST_IDLE) begin
            cur_x    = I_X0;
            cur_y    = I_Y0;
            cur_base = ADDR_W'(I_Y0) * STRIDE;
            sel_x0   = I_X0;
            sel_x1   = x1_clamp;
            sel_y1   = y1_clamp;
            sel_mode = I_CMD_MODE;
            sel_a    = I_COLOR_A;
            sel_b    = I_COLOR_B;
        end else begin
            cur_x    = x_q;
            cur_y    = y_q;
            cur_base = base_q;
            sel_x0   = x0_q;
            sel_x1   = x1_q;
            sel_y1   = y1_q;
            sel_mode = mode_q;
            sel_a    = color_a_q;
            sel_b    = color_b_q;
        end
    end

    // Raster advance from the current pixel.
    logic               at_row_end, is_last, draw_req, issue;
    logic [COORD_W-1:0] nxt_x, nxt_y;
    logic [ADDR_W-1:0]  nxt_base;
    logic [DATA_W-1:0]  pix_color;

    assign at_row_end = (cur_x == sel_x1);
    assign is_last    = at_row_end && (cur_y == sel_y1);
    assign nxt_x      = at_row_end ? sel_x0 : cur_x + COORD_W'(1);
    assign nxt_y      = at_row_end ? cur_y + COORD_W'(1) : cur_y;
    assign nxt_base   = at_row_end ? cur_base + STRIDE : cur_base;

    assign draw_req = (state == ST_IDLE) ? (I_CMD_VALID && !cmd_empty)
                                         : ((state == ST_DRAW) && pend_q);
    assign issue    = draw_req && !I_VIDEO_ON;

    gpu_pixel_color #(
        .DATA_W      (DATA_W)
    ) u_pixel_color (
        .mode        (sel_mode),
        .chk_x       (cur_x[CHK_BIT]),
        .chk_y       (cur_y[CHK_BIT]),
        .blink_phase (cnt_q[BLINK_BIT]),
        .color_a     (sel_a),
        .color_b     (sel_b),
        .color       (pix_color)
    );

    assign O_CMD_READY = (state == ST_IDLE);
    assign O_GPU_READ  = 1'b0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state            <= ST_IDLE;
            mode_q           <= MODE_SOLID;
            color_a_q        <= '0;
            color_b_q        <= '0;
            x0_q             <= '0;
            x1_q             <= '0;
            y1_q             <= '0;
            x_q              <= '0;
            y_q              <= '0;
            base_q           <= '0;
            pend_q           <= 1'b0;
            cnt_q            <= '0;
            O_GPU_ADDR       <= '0;
            O_GPU_DATA       <= '0;
            O_GPU_WRITE      <= 1'b0;
            O_GPUStallSignal <= 1'b0;
            O_DONE           <= 1'b0;
        end else begin
            cnt_q       <= cnt_q + (BLINK_BIT+1)'(1);
            O_GPU_WRITE <= issue;
            if (issue) begin
                O_GPU_ADDR <= cur_base + ADDR_W'(cur_x);
                O_GPU_DATA <= pix_color;
            end

            case (state)
                ST_IDLE: begin
                    if (I_CMD_VALID) begin
                        mode_q    <= I_CMD_MODE;
                        color_a_q <= I_COLOR_A;
                        color_b_q <= I_COLOR_B;
                        x0_q      <= I_X0;
                        x1_q      <= x1_clamp;
                        y1_q      <= y1_clamp;
                        if (cmd_empty) begin
                            state  <= ST_DONE;
                            O_DONE <= 1'b1;
                        end else begin
                            state            <= ST_DRAW;
                            O_GPUStallSignal <= 1'b1;
                            x_q              <= issue ? nxt_x    : cur_x;
                            y_q              <= issue ? nxt_y    : cur_y;
                            base_q           <= issue ? nxt_base : cur_base;
                            pend_q           <= !(issue && is_last);
                        end
                    end
                end
                ST_DRAW: begin
                    // The cycle after the last write leaves DRAW, so the last
                    // write and O_DONE never overlap.
                    if (!pend_q) begin
                        state            <= ST_DONE;
                        O_GPUStallSignal <= 1'b0;
                        O_DONE           <= 1'b1;
                    end else if (issue) begin
                        x_q    <= nxt_x;
                        y_q    <= nxt_y;
                        base_q <= nxt_base;
                        pend_q <= !is_last;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    O_DONE <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_rect_fill.sv
`timescale 1ns/1ps

module tb_gpu_rect_fill;

    localparam int H_RES     = 640;
    localparam int V_RES     = 400;
    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 16;
    localparam int COORD_W   = 10;
    localparam int CHK_BIT   = 3;
    localparam int BLINK_BIT = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               video_on;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_mode;
    logic [COORD_W-1:0] x0, y0, x1, y1;
    logic [DATA_W-1:0]  ca, cb;
    logic [ADDR_W-1:0]  gpu_addr;
    logic [DATA_W-1:0]  gpu_data;
    logic               gpu_write, gpu_read, stall, done;

    always #5 clk = ~clk;

    gpu_rect_fill #(
        .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .COORD_W(COORD_W), .CHK_BIT(CHK_BIT), .BLINK_BIT(BLINK_BIT)
    ) dut (
        .I_CLK            (clk),
        .I_RST_N          (rst_n),
        .I_VIDEO_ON       (video_on),
        .I_CMD_VALID      (cmd_valid),
        .O_CMD_READY      (cmd_ready),
        .I_CMD_MODE       (cmd_mode),
        .I_X0             (x0),
        .I_Y0             (y0),
        .I_X1             (x1),
        .I_Y1             (y1),
        .I_COLOR_A        (ca),
        .I_COLOR_B        (cb),
        .O_GPU_ADDR       (gpu_addr),
        .O_GPU_DATA       (gpu_data),
        .O_GPU_WRITE      (gpu_write),
        .O_GPU_READ       (gpu_read),
        .O_GPUStallSignal (stall),
        .O_DONE           (done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected SRAM writes, in raster order.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        bit                is_blink;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: enumerate the clamped rectangle row by row.
    task automatic model_cmd(input logic [1:0] m, input int ix0, input int iy0, input int ix1,
                             input int iy1, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             output int n);
        int cx1, cy1;
        cx1 = (ix1 > H_RES-1) ? H_RES-1 : ix1;
        cy1 = (iy1 > V_RES-1) ? V_RES-1 : iy1;
        n = 0;
        if (ix0 > cx1 || iy0 > cy1 || ix0 >= H_RES || iy0 >= V_RES) return;
        for (int yy = iy0; yy <= cy1; yy++) begin
            for (int xx = ix0; xx <= cx1; xx++) begin
                exp_t e;
                e.addr     = ADDR_W'(yy * H_RES + xx);
                e.a        = a;
                e.b        = b;
                e.is_blink = (m == 2'd2);
                if (m == 2'd1 && (((xx >> CHK_BIT) ^ (yy >> CHK_BIT)) & 1) == 1) e.data = b;
                else e.data = a;
                sb_q.push_back(e);
                n++;
            end
        end
    endtask

    // Edges since reset release: the blink phase of a write is bit BLINK_BIT
    // of the number of edges that preceded the edge issuing it.
    int   tb_cnt = 0;
    logic vid_q  = 1'b0;
    int   writes_seen = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 0;
        else        tb_cnt <= tb_cnt + 1;
    end

    always @(posedge clk) vid_q <= video_on;

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [DATA_W-1:0] d;
        if (rst_n === 1'b1 && gpu_write === 1'b1) begin
            writes_seen++;
            last_addr = gpu_addr;
            check("write_while_video_on", 32'(vid_q), 0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h, no write expected", gpu_addr, gpu_data);
            end else begin
                e = sb_q.pop_front();
                d = e.data;
                if (e.is_blink) d = (((tb_cnt - 1) >> BLINK_BIT) & 1) ? e.b : e.a;
                check("write_addr", 32'(gpu_addr), 32'(e.addr));
                check("write_data", 32'(gpu_data), 32'(d));
            end
        end
    end

    task automatic start_cmd(input logic [1:0] m, input int ix0, input int iy0, input int ix1,
                             input int iy1, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input int vmode, output int n);
        @(negedge clk);
        check("ready_before_cmd", 32'(cmd_ready), 1);
        video_on  = (vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        x0 = COORD_W'(ix0); y0 = COORD_W'(iy0);
        x1 = COORD_W'(ix1); y1 = COORD_W'(iy1);
        ca = a; cb = b;
        model_cmd(m, ix0, iy0, ix1, iy1, a, b, n);
        @(posedge clk);
        #1;
        // Scramble the command bus to prove the engine latched it.
        cmd_valid = 1'b0;
        cmd_mode  = 2'($urandom);
        x0 = COORD_W'($urandom); y0 = COORD_W'($urandom);
        x1 = COORD_W'($urandom); y1 = COORD_W'($urandom);
        ca = DATA_W'($urandom);  cb = DATA_W'($urandom);
    endtask

    // vmode: 0 always blanked, 1 random video, 2 video on for three edges.
    task automatic finish_cmd(input string tag, input int n, input int vmode, input bit poke,
                              input int writes_before);
        bit got = 1'b0;
        int lat = 0;
        for (int c = 1; c <= 5000 && !got; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                lat = c;
            end else begin
                check({tag, "_stall"}, 32'(stall), 1);
            end
            if (poke) begin
                if (c == 2) begin
                    cmd_valid = 1'b1; cmd_mode = 2'd0;
                    x0 = 0; y0 = 0; x1 = 3; y1 = 0; ca = 16'h0ABC;
                end else if (c == 3) begin
                    cmd_valid = 1'b0;
                end
            end
            case (vmode)
                1:       video_on = 1'($urandom_range(0, 1));
                2:       video_on = (c >= 2 && c <= 4);
                default: video_on = 1'b0;
            endcase
        end
        video_on = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got no O_DONE in 5000 cycles, required one", tag);
        end else begin
            check({tag, "_write_at_done"}, 32'(gpu_write), 0);
            check({tag, "_stall_at_done"}, 32'(stall), 0);
            check({tag, "_ready_at_done"}, 32'(cmd_ready), 0);
            check({tag, "_pending_writes"}, 32'(sb_q.size()), 0);
            check({tag, "_write_count"}, 32'(writes_seen - writes_before), 32'(n));
            if (vmode == 0) check({tag, "_done_latency"}, 32'(lat), 32'(n + 1));
            @(negedge clk);
            check({tag, "_ready_after"}, 32'(cmd_ready), 1);
            check({tag, "_done_pulse"}, 32'(done), 0);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] m, input int ix0, input int iy0,
                           input int ix1, input int iy1, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input int vmode, input bit poke);
        int n, wb;
        wb = writes_seen;
        start_cmd(m, ix0, iy0, ix1, iy1, a, b, vmode, n);
        finish_cmd(tag, n, vmode, poke, wb);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n, ix0, iy0, ix1, iy1, vmode;
        logic [1:0] m;

        rst_n = 1'b0; video_on = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; ca = '0; cb = '0;
        #12;
        check("rst_addr",  32'(gpu_addr), 0);
        check("rst_data",  32'(gpu_data), 0);
        check("rst_write", 32'(gpu_write), 0);
        check("rst_read",  32'(gpu_read), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_done",  32'(done), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd("solid2x2",   2'd0, 1, 1, 2, 2, 16'h0F00, 16'h0000, 0, 1'b0);
        run_cmd("solid_blank", 2'd0, 1, 1, 2, 2, 16'h0F00, 16'h0000, 2, 1'b0);
        run_cmd("checker",    2'd1, 0, 0, 15, 0, 16'h0FFF, 16'h0000, 0, 1'b0);
        run_cmd("empty",      2'd0, 5, 0, 4, 0, 16'h0123, 16'h0456, 0, 1'b0);
        run_cmd("clamp",      2'd0, 630, 399, 1000, 900, 16'h00F0, 16'h0000, 0, 1'b0);
        check("clamp_last_addr", 32'(last_addr), 255999);
        run_cmd("blink",      2'd2, 100, 50, 105, 52, 16'h0A0A, 16'h0505, 0, 1'b0);
        run_cmd("reserved",   2'd3, 8, 8, 12, 9, 16'h0321, 16'h0FFF, 0, 1'b0);
        run_cmd("poke",       2'd0, 0, 20, 15, 20, 16'h0333, 16'h0000, 0, 1'b1);

        // Reset in the middle of a fill abandons it.
        start_cmd(2'd0, 0, 10, 15, 13, 16'h0555, 16'h0000, 0, n);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_write", 32'(gpu_write), 0);
        check("midrst_addr",  32'(gpu_addr), 0);
        check("midrst_stall", 32'(stall), 0);
        check("midrst_ready", 32'(cmd_ready), 1);
        sb_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_idle_done", 32'(done), 0);
        end
        run_cmd("after_reset", 2'd1, 4, 4, 19, 6, 16'h0111, 16'h0EEE, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            ix0 = $urandom_range(0, 700);
            iy0 = $urandom_range(0, 410);
            ix1 = ix0 + int'($urandom_range(0, 20)) - 2;
            iy1 = iy0 + int'($urandom_range(0, 6)) - 1;
            if (ix1 < 0) ix1 = 0;
            if (iy1 < 0) iy1 = 0;
            m     = 2'($urandom_range(0, 3));
            vmode = $urandom_range(0, 1);
            run_cmd("random", m, ix0, iy0, ix1, iy1, 16'($urandom), 16'($urandom), vmode, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
